fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, meaning the maximum cycles spent waiting for imemValid before a bus error.
REQ-003 SHALL have ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imemReq  out  1  instruction memory request.
- imemAddr  out  32  fetch address (equals pc).
- imemRdata  in  32  instruction word.
- imemValid  in  1  imemRdata is valid.
- branch  in  1  branch flag from the control unit.
- jump  in  1  jump flag from the control unit.
- zero  in  1  ALU zero flag.
- pcTarget  in  32  branch/jump target computed by the datapath.
- stall  in  1  hold the current instruction.
- instr  out  32  instruction register.
- op  out  7  instr[6:0].
- f3  out  3  instr[14:12].
- f7  out  1  instr[30].
- pc  out  32  address of instr.
- pcPlus4  out  32  pc+4.
- instrValid  out  1  instr/op/f3/f7 are valid for execution this cycle.
- misaligned  out  1  sticky: the target address was misaligned.
- busErr  out  1  sticky: fetch timeout.

Function
REQ-004 SHALL implement states RST, FETCH, EXEC and HALT.
REQ-005 SHALL leave RST for FETCH on the first clock after rst_n deasserts.
REQ-006 In FETCH, SHALL drive imemReq=1 and imemAddr=pc, and SHALL sample imemValid every cycle, including the first.
REQ-007 On FETCH with imemValid=1, SHALL latch imemRdata into instr, clear the wait counter and go to EXEC; minimum throughput is 2 cycles per instruction.
REQ-008 On FETCH with imemValid=0, SHALL increment a wait counter; on the cycle the counter reaches MAX_WAIT it SHALL set busErr and go to HALT.
REQ-009 SHALL ignore imemValid outside FETCH.
REQ-010 SHALL assert instrValid only in EXEC, and SHALL drive imemReq=0 in every state other than FETCH.
REQ-011 In EXEC with stall=1, SHALL hold state, pc and instr, and SHALL keep instrValid=1.
REQ-012 In EXEC with stall=0, SHALL compute pcSrc=(branch&zero)|jump and next=pcSrc ? pcTarget : pcPlus4.
REQ-013 If next[1:0]!=2'b00, SHALL keep pc unchanged, set misaligned and go to HALT.
REQ-014 Otherwise SHALL load pc<=next and go to FETCH.
REQ-015 SHALL compute pcPlus4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-016 HALT SHALL be absorbing until reset: imemReq=0, instrValid=0, all state held.
REQ-017 SHALL decode op, f3 and f7 combinationally from instr, with no added latency.
REQ-018 If stall and imemValid are asserted together while in FETCH, SHALL ignore stall (stall acts only in EXEC).

Reset
REQ-019 SHALL apply the following immediately when rst_n=0, independent of clk and of the current state: state=RST, pc=RESET_PC, instr=32'h00000013 (addi x0,x0,0), wait counter=0, misaligned=0, busErr=0, instrValid=0, imemReq=0.
REQ-020 A reset asserted mid-FETCH SHALL drop imemReq in the same cycle; a memory response arriving during reset SHALL be discarded.

Structure
REQ-021 SHALL take the state encoding (2 bits), the NOP constant 32'h00000013 and the opcode field bit positions from a shared package, riscv_pkg.
REQ-022 SHALL put the next-PC selection (REQ-012, REQ-013, REQ-015) in one combinational sub-module, next_pc; all registers SHALL stay in fetch_unit.

Verification
REQ-023 Reset with RESET_PC=0 and memory returning valid in the same cycle as the request -> imemAddr shows 0, 4, 8 on successive FETCH cycles, and instrValid pulses every 2nd cycle.
REQ-024 Branch cases:
- branch=1, zero=1, pcTarget=32'h40 in EXEC -> next imemAddr=32'h40.
- branch=1, zero=0 -> next imemAddr=pc+4.
- jump=1, zero=0, pcTarget=32'h80 -> next imemAddr=32'h80.
REQ-025 jump=1, pcTarget=32'h42 -> misaligned=1, state HALT, imemReq=0, pc unchanged; the unit stays halted until rst_n pulses.
REQ-026 stall=1 for 3 EXEC cycles -> instrValid=1 and pc/instr stable for 3 cycles; FETCH of pc+4 follows the cycle after stall drops.
REQ-027 imemValid held 0 -> busErr=1 after MAX_WAIT=15 FETCH cycles, then HALT; imemValid=1 on the 15th cycle -> normal EXEC, no error.
REQ-028 Reset and wrap cases:
- rst_n low mid-FETCH at pc=32'h10 -> imemReq=0 and pc=RESET_PC asynchronously; instr=32'h00000013.
- Separately, pc=32'hFFFFFFFC with no branch -> next imemAddr=32'h0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the NOP word and the
// bit positions of the opcode fields decoded from the instruction register.
package riscv_pkg;

   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam int OP_LO  = 0;
   localparam int OP_HI  = 6;
   localparam int F3_LO  = 12;
   localparam int F3_HI  = 14;
   localparam int F7_BIT = 30;

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: sequential pc+4 (wrapping at 2^32) or the
// branch/jump target, plus a flag for a target that is not word aligned.
module next_pc (
   input  logic        [31:0] pc,
   input  logic        [31:0] pcTarget,
   input  logic               branch,
   input  logic               jump,
   input  logic               zero,
   output logic        [31:0] pcPlus4,
   output logic        [31:0] nextPc,
   output logic               misalign
);

   logic pcSrc;

   assign pcPlus4  = pc + 32'd4;
   assign pcSrc    = (branch & zero) | jump;
   assign nextPc   = pcSrc ? pcTarget : pcPlus4;
   assign misalign = (nextPc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: alternates FETCH/EXEC, holds on stall, and halts
// permanently on a misaligned target or a memory that never answers.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h00000000,
   parameter int          MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemRdata,
   input  logic        imemValid,
   input  logic        branch,
   input  logic        jump,
   input  logic        zero,
   input  logic [31:0] pcTarget,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic [2:0]  f3,
   output logic        f7,
   output logic [31:0] pc,
   output logic [31:0] pcPlus4,
   output logic        instrValid,
   output logic        misaligned,
   output logic        busErr
);

   localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   fetch_state_t      state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       nextPc;
   logic              nextMis;
   logic              timeout;

   next_pc u_next_pc (
      .pc       (pc),
      .pcTarget (pcTarget),
      .branch   (branch),
      .jump     (jump),
      .zero     (zero),
      .pcPlus4  (pcPlus4),
      .nextPc   (nextPc),
      .misalign (nextMis)
   );

   // This miss is the one that brings the counter up to MAX_WAIT.
   assign timeout = !imemValid && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RST;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RST:   state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (imemValid)    state_nxt = ST_EXEC;
            else if (timeout) state_nxt = ST_HALT;
         end
         ST_EXEC:  if (!stall) state_nxt = nextMis ? ST_HALT : ST_FETCH;
         ST_HALT:  state_nxt = ST_HALT;
         default:  state_nxt = ST_RST;
      endcase
   end

   always_comb begin
      imemReq    = (state == ST_FETCH);
      instrValid = (state == ST_EXEC);
   end

   assign imemAddr = pc;
   assign op       = instr[OP_HI:OP_LO];
   assign f3       = instr[F3_HI:F3_LO];
   assign f7       = instr[F7_BIT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         instr      <= NOP_INSTR;
         wait_cnt   <= '0;
         misaligned <= 1'b0;
         busErr     <= 1'b0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (imemValid) begin
                  instr    <= imemRdata;
                  wait_cnt <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
                  if (timeout) busErr <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (!stall) begin
                  if (nextMis) misaligned <= 1'b1;
                  else         pc         <= nextPc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a driver plays memory and control unit and
// queues the expected instruction stream; a monitor checks every cycle.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h00000000;
   localparam int          MAX_WAIT = 15;
   localparam logic [31:0] NOP      = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata;
   logic        imemValid;
   logic        branch, jump, zero;
   logic [31:0] pcTarget;
   logic        stall;
   logic [31:0] instr;
   logic [6:0]  op;
   logic [2:0]  f3;
   logic        f7;
   logic [31:0] pc, pcPlus4;
   logic        instrValid, misaligned, busErr;

   fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imemReq    (imemReq),
      .imemAddr   (imemAddr),
      .imemRdata  (imemRdata),
      .imemValid  (imemValid),
      .branch     (branch),
      .jump       (jump),
      .zero       (zero),
      .pcTarget   (pcTarget),
      .stall      (stall),
      .instr      (instr),
      .op         (op),
      .f3         (f3),
      .f7         (f7),
      .pc         (pc),
      .pcPlus4    (pcPlus4),
      .instrValid (instrValid),
      .misaligned (misaligned),
      .busErr     (busErr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        br;
      logic        jmp;
      logic        z;
      logic [31:0] tgt;
      logic [1:0]  nstall;
   } act_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t exp_q[$];
   act_t dir_q[$];
   bit   force_q[$];

   int          vprob;
   bit          rand_en;
   logic [31:0] mpc;
   bit          act_busy;
   act_t        cur;
   int          stall_left;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   function automatic act_t rand_act(input bit en);
      act_t a;
      a.br     = en & 1'($urandom);
      a.jmp    = en & ($urandom_range(0, 3) == 0);
      a.z      = 1'($urandom);
      a.tgt    = {22'h0, 8'($urandom), 2'b00};
      a.nstall = (en && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      return a;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One cycle of stimulus, applied 2 time units after the rising edge.
   task automatic step();
      logic [31:0] nxt;
      @(posedge clk);
      #2;
      if (imemReq) begin
         imemRdata = mem_word(imemAddr);
         if (force_q.size() > 0) imemValid = force_q.pop_front();
         else                    imemValid = ($urandom_range(0, 99) < vprob);
         stall    = 1'($urandom);
         branch   = 1'($urandom);
         jump     = 1'($urandom);
         zero     = 1'($urandom);
         pcTarget = $urandom;
      end else if (instrValid) begin
         imemValid = 1'($urandom);
         imemRdata = $urandom;
         if (!act_busy) begin
            if (dir_q.size() > 0) cur = dir_q.pop_front();
            else                  cur = rand_act(rand_en);
            stall_left = int'(cur.nstall);
            act_busy   = 1'b1;
         end
         if (stall_left > 0) begin
            stall_left--;
            stall    = 1'b1;
            branch   = 1'($urandom);
            jump     = 1'($urandom);
            zero     = 1'($urandom);
            pcTarget = $urandom;
         end else begin
            stall    = 1'b0;
            branch   = cur.br;
            jump     = cur.jmp;
            zero     = cur.z;
            pcTarget = cur.tgt;
            act_busy = 1'b0;
            nxt = ((cur.br & cur.z) | cur.jmp) ? cur.tgt : mpc + 32'd4;
            if (nxt[1:0] == 2'b00) begin
               mpc = nxt;
               exp_q.push_back('{pc: nxt, ins: mem_word(nxt)});
            end
         end
      end else begin
         imemValid = 1'($urandom);
         imemRdata = $urandom;
         stall     = 1'($urandom);
         branch    = 1'($urandom);
         jump      = 1'($urandom);
         zero      = 1'($urandom);
         pcTarget  = $urandom;
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      imemValid = 1'b1;
      imemRdata = $urandom;
      #1;
      chk("rst_imemReq", imemReq, 0);
      chk("rst_instrValid", instrValid, 0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_imemAddr", imemAddr, RESET_PC);
      chk("rst_instr", instr, NOP);
      chk("rst_misaligned", misaligned, 0);
      chk("rst_busErr", busErr, 0);
      exp_q.delete();
      dir_q.delete();
      force_q.delete();
      act_busy   = 1'b0;
      stall_left = 0;
      mpc        = RESET_PC;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_discard_instr", instr, NOP);
      chk("rst_hold_imemReq", imemReq, 0);
      exp_q.push_back('{pc: RESET_PC, ins: mem_word(RESET_PC)});
      rst_n = 1'b1;
   endtask

   // Monitor: expected outputs for the next cycle are derived from what was
   // seen and driven this cycle.
   exp_t        e;
   int          wcnt = 0;
   bit          have_exp = 1'b0;
   bit          e_req, e_iv, e_bus, e_mis;
   logic [31:0] halt_pc;

   always @(negedge clk) begin
      if (!rst_n) begin
         wcnt     = 0;
         have_exp = 1'b0;
         e_bus    = 1'b0;
         e_mis    = 1'b0;
      end else begin
         if (have_exp) begin
            chk("imemReq", imemReq, e_req);
            chk("instrValid", instrValid, e_iv);
            chk("busErr", busErr, e_bus);
            chk("misaligned", misaligned, e_mis);
         end
         have_exp = 1'b1;
         if (instrValid) begin
            if (exp_q.size() == 0) begin
               chk("exec_expected", 0, 1);
               e_req = 1'b0;
               e_iv  = 1'b0;
            end else begin
               e = exp_q[0];
               chk("pc", pc, e.pc);
               chk("instr", instr, e.ins);
               chk("op", op, e.ins[6:0]);
               chk("f3", f3, e.ins[14:12]);
               chk("f7", f7, e.ins[30]);
               chk("pcPlus4", pcPlus4, e.pc + 32'd4);
               if (stall) begin
                  e_req = 1'b0;
                  e_iv  = 1'b1;
               end else begin
                  void'(exp_q.pop_front());
                  e_iv  = 1'b0;
                  e_req = (exp_q.size() != 0);
                  if (exp_q.size() == 0) begin
                     e_mis   = 1'b1;
                     halt_pc = e.pc;
                  end
               end
            end
         end else if (imemReq) begin
            if (exp_q.size() == 0) begin
               chk("fetch_expected", 0, 1);
               e_req = 1'b0;
               e_iv  = 1'b0;
            end else begin
               chk("imemAddr", imemAddr, exp_q[0].pc);
               if (imemValid) begin
                  wcnt  = 0;
                  e_req = 1'b0;
                  e_iv  = 1'b1;
               end else begin
                  wcnt++;
                  e_iv = 1'b0;
                  if (wcnt >= MAX_WAIT) begin
                     e_bus   = 1'b1;
                     e_req   = 1'b0;
                     halt_pc = exp_q[0].pc;
                  end else begin
                     e_req = 1'b1;
                  end
               end
            end
         end else begin
            e_req = !(e_bus || e_mis);
            e_iv  = 1'b0;
            if (e_bus || e_mis) chk("halt_pc", pc, halt_pc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      rst_n     = 1'b1;
      imemRdata = '0;
      imemValid = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      zero      = 1'b0;
      pcTarget  = '0;
      stall     = 1'b0;
      act_busy  = 1'b0;
      stall_left = 0;
      mpc       = RESET_PC;
      @(posedge clk);
      #2;
      do_reset();

      // Full-rate sequential fetch, then reset while fetching 0x10.
      vprob   = 100;
      rand_en = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (imemReq && imemAddr == 32'h10) found = 1'b1;
      end
      chk("reach_fetch_0x10", 32'(found), 1);
      do_reset();

      // Directed branch/jump/stall/wrap cases, then random traffic.
      dir_q.push_back('{br: 1'b1, jmp: 1'b0, z: 1'b1, tgt: 32'h40,       nstall: 2'd0});
      dir_q.push_back('{br: 1'b1, jmp: 1'b0, z: 1'b0, tgt: 32'h200,      nstall: 2'd0});
      dir_q.push_back('{br: 1'b0, jmp: 1'b1, z: 1'b0, tgt: 32'h80,       nstall: 2'd0});
      dir_q.push_back('{br: 1'b0, jmp: 1'b0, z: 1'b0, tgt: 32'h300,      nstall: 2'd3});
      dir_q.push_back('{br: 1'b0, jmp: 1'b1, z: 1'b1, tgt: 32'hFFFFFFFC, nstall: 2'd0});
      dir_q.push_back('{br: 1'b0, jmp: 1'b0, z: 1'b1, tgt: 32'h100,      nstall: 2'd0});
      vprob   = 60;
      rand_en = 1'b1;
      repeat (300) step();

      // Memory answers on the last allowed cycle: no error.
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         found = instrValid;
      end
      chk("reach_exec_late_valid", 32'(found), 1);
      repeat (MAX_WAIT - 1) force_q.push_back(1'b0);
      force_q.push_back(1'b1);
      repeat (40) step();
      chk("late_valid_no_busErr", busErr, 0);

      // Memory never answers: bus error and halt.
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         step();
         found = instrValid;
      end
      chk("reach_exec_timeout", 32'(found), 1);
      repeat (MAX_WAIT) force_q.push_back(1'b0);
      repeat (40) step();
      chk("timeout_busErr", busErr, 1);
      chk("timeout_halt_req", imemReq, 0);
      do_reset();

      // Misaligned jump target halts with pc unchanged.
      vprob   = 100;
      rand_en = 1'b0;
      dir_q.push_back('{br: 1'b0, jmp: 1'b1, z: 1'b0, tgt: 32'h42, nstall: 2'd0});
      repeat (20) step();
      chk("mis_flag", misaligned, 1);
      chk("mis_halt_req", imemReq, 0);
      chk("mis_halt_valid", instrValid, 0);
      chk("mis_pc_kept", pc, RESET_PC);
      do_reset();
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
